// File: rtl/enemy_car_spawner_pkg.sv
// monaco_pkg: shared widths, lane geometry defaults and spawner FSM encoding.
package monaco_pkg;
    localparam int COORD_W = 10;
    localparam int LANE_W = 2;
    localparam int NUM_LANES = 4;
    localparam int CNT_W = 8;
    localparam int DEF_Y_MAX = 479;
    localparam int DEF_LANE_X0 = 224;
    localparam int DEF_LANE_PITCH = 48;
    typedef logic [1:0] state_t;
    localparam state_t S_WAIT = 2'd0;
    localparam state_t S_MOVE = 2'd1;
    localparam state_t S_SPAWN = 2'd2;
endpackage

// File: rtl/enemy_car_spawner_if.sv
// enemy_car_spawner_if: frame control, random input and rival car outputs.
interface enemy_car_spawner_if #(parameter int NUM_CARS = 4);
    logic frame_tick;
    logic run;
    logic [7:0] rand_in;
    logic [3:0] player_speed;
    logic [NUM_CARS-1:0] car_active;
    logic [10*NUM_CARS-1:0] car_x;
    logic [10*NUM_CARS-1:0] car_y;
    logic spawn_pulse;
    logic busy;
    modport master(output frame_tick, run, rand_in, player_speed,
                   input car_active, car_x, car_y, spawn_pulse, busy);
    modport slave(input frame_tick, run, rand_in, player_speed,
                  output car_active, car_x, car_y, spawn_pulse, busy);
endinterface

// File: rtl/enemy_car_spawner_lane_picker.sv
// lane_picker: choose a spawn lane, nudging it one lane over to avoid stacking.
import monaco_pkg::*;
module lane_picker #(
    parameter int LANE_X0 = DEF_LANE_X0,
    parameter int LANE_PITCH = DEF_LANE_PITCH
) (
    input  logic [2:0]         rand_bits,
    input  logic [LANE_W-1:0]  last_lane,
    output logic [LANE_W-1:0]  lane,
    output logic [COORD_W-1:0] x
);
    always_comb begin
        lane = (rand_bits[1:0] == last_lane && rand_bits[2]) ? rand_bits[1:0] + 2'd1 : rand_bits[1:0];
        x = COORD_W'(LANE_X0 + LANE_PITCH * int'(lane));
    end
endmodule

// File: rtl/enemy_car_spawner.sv
// enemy_car_spawner: per-frame rival car advance/retire and randomised spawning.
import monaco_pkg::*;
module enemy_car_spawner #(
    parameter int NUM_CARS = 4,
    parameter int LANE_X0 = DEF_LANE_X0,
    parameter int LANE_PITCH = DEF_LANE_PITCH,
    parameter int Y_MAX = DEF_Y_MAX,
    parameter int SPAWN_MIN = 32
) (
    input logic clk,
    input logic reset,
    enemy_car_spawner_if.slave bus
);
    localparam int IW = $clog2(NUM_CARS);
    state_t state;
    logic [IW-1:0] idx, free_idx;
    logic free_found;
    logic [CNT_W-1:0] spawn_cnt;
    logic [LANE_W-1:0] last_lane, pick_lane;
    logic [COORD_W-1:0] pick_x;
    logic [COORD_W-1:0] xs [NUM_CARS];
    logic [COORD_W-1:0] ys [NUM_CARS];
    logic [NUM_CARS-1:0] active;
    logic [COORD_W:0] sum;
    logic busy_r, pulse_r;

    lane_picker #(.LANE_X0(LANE_X0), .LANE_PITCH(LANE_PITCH)) picker (
        .rand_bits(bus.rand_in[2:0]),
        .last_lane(last_lane),
        .lane(pick_lane),
        .x(pick_x)
    );

    assign sum = {1'b0, ys[idx]} + (COORD_W+1)'(bus.player_speed);

    // lowest-index free slot wins
    always_comb begin
        free_found = 1'b0;
        free_idx = '0;
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_found = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_pack
        assign bus.car_x[COORD_W*g +: COORD_W] = xs[g];
        assign bus.car_y[COORD_W*g +: COORD_W] = ys[g];
    end
    assign bus.car_active = active;
    assign bus.busy = busy_r;
    assign bus.spawn_pulse = pulse_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_WAIT;
            idx <= '0;
            spawn_cnt <= CNT_W'(SPAWN_MIN);
            last_lane <= '0;
            active <= '0;
            busy_r <= 1'b0;
            pulse_r <= 1'b0;
            for (int i = 0; i < NUM_CARS; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else begin
            pulse_r <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (bus.frame_tick && bus.run) begin
                        state <= S_MOVE;
                        idx <= '0;
                        busy_r <= 1'b1;
                    end
                end
                S_MOVE: begin
                    if (active[idx]) begin
                        if (sum > (COORD_W+1)'(Y_MAX)) begin
                            active[idx] <= 1'b0;
                            ys[idx] <= '0;
                        end else begin
                            ys[idx] <= sum[COORD_W-1:0];
                        end
                    end
                    idx <= idx + 1'b1;
                    if (idx == IW'(NUM_CARS - 1)) state <= S_SPAWN;
                end
                S_SPAWN: begin
                    state <= S_WAIT;
                    busy_r <= 1'b0;
                    if (spawn_cnt != '0) begin
                        spawn_cnt <= spawn_cnt - 1'b1;
                    end else if (free_found) begin
                        active[free_idx] <= 1'b1;
                        xs[free_idx] <= pick_x;
                        ys[free_idx] <= '0;
                        last_lane <= pick_lane;
                        spawn_cnt <= CNT_W'(SPAWN_MIN) + CNT_W'(bus.rand_in[7:3]);
                        pulse_r <= 1'b1;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_enemy_car_spawner.sv
// tb_enemy_car_spawner: directed checks of movement, retirement, spawning and reset.
module tb_enemy_car_spawner;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enemy_car_spawner_if #(.NUM_CARS(N)) ifc ();
    enemy_car_spawner #(.NUM_CARS(N)) dut (.clk(clk), .reset(reset), .bus(ifc));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] xof(input int i);
        return ifc.car_x[10*i +: 10];
    endfunction

    function automatic logic [9:0] yof(input int i);
        return ifc.car_y[10*i +: 10];
    endfunction

    task automatic frame(input logic [7:0] r);
        ifc.rand_in = r;
        ifc.frame_tick = 1'b1;
        step();
        ifc.frame_tick = 1'b0;
        step(N + 1);
    endtask

    task automatic frames(input int n);
        repeat (n) frame(8'h00);
    endtask

    initial begin
        reset = 1'b0;
        ifc.frame_tick = 1'b0;
        ifc.run = 1'b1;
        ifc.rand_in = 8'h00;
        ifc.player_speed = 4'd0;
        step(2);
        check("rst_active", 32'(ifc.car_active), 0);
        check("rst_x", 32'(ifc.car_x), 0);
        check("rst_y", 32'(ifc.car_y), 0);
        check("rst_pulse", 32'(ifc.spawn_pulse), 0);
        check("rst_busy", 32'(ifc.busy), 0);
        reset = 1'b1;
        step();

        ifc.frame_tick = 1'b1;
        step();
        ifc.frame_tick = 1'b0;
        step();
        check("busy_high", 32'(ifc.busy), 1);
        step(N + 1);
        check("busy_low", 32'(ifc.busy), 0);
        frames(30);
        frame(8'h00);
        check("no_spawn_f32", 32'(ifc.spawn_pulse), 0);
        check("none_active_f32", 32'(ifc.car_active), 0);

        frame(8'h05);
        check("spawn_pulse_f33", 32'(ifc.spawn_pulse), 1);
        check("spawn_active0", 32'(ifc.car_active), 4'b0001);
        check("spawn_x0", 32'(xof(0)), 272);
        check("spawn_y0", 32'(yof(0)), 0);
        step();
        check("pulse_one_cycle", 32'(ifc.spawn_pulse), 0);

        frames(31);
        frame(8'h00);
        check("no_early_spawn", 32'(ifc.spawn_pulse), 0);
        frame(8'h05);
        check("antistack_active", 32'(ifc.car_active), 4'b0011);
        check("antistack_x1", 32'(xof(1)), 320);

        frames(32);
        frame(8'h02);
        check("noshift_active", 32'(ifc.car_active), 4'b0111);
        check("noshift_x2", 32'(xof(2)), 320);

        frames(32);
        frame(8'h1B);
        check("lane3_active", 32'(ifc.car_active), 4'b1111);
        check("lane3_x3", 32'(xof(3)), 368);

        frames(34);
        frame(8'h00);
        check("cnt35_no_spawn_yet", 32'(ifc.spawn_pulse), 0);
        frame(8'h00);
        check("full_no_spawn", 32'(ifc.spawn_pulse), 0);
        check("full_active", 32'(ifc.car_active), 4'b1111);

        ifc.player_speed = 4'd14;
        frames(34);
        check("advance_y0", 32'(yof(0)), 476);
        check("advance_y3", 32'(yof(3)), 476);
        check("advance_active", 32'(ifc.car_active), 4'b1111);

        ifc.player_speed = 4'd3;
        ifc.frame_tick = 1'b1;
        step();
        ifc.frame_tick = 1'b0;
        step();
        check("stagger_y0", 32'(yof(0)), 479);
        check("stagger_y1_old", 32'(yof(1)), 476);
        step();
        check("stagger_y1_new", 32'(yof(1)), 479);
        step(3);
        check("ymax_still_active", 32'(ifc.car_active), 4'b1111);
        check("ymax_y3", 32'(yof(3)), 479);
        check("ymax_no_spawn", 32'(ifc.spawn_pulse), 0);

        ifc.player_speed = 4'd1;
        frame(8'h07);
        check("retire_respawn_active", 32'(ifc.car_active), 4'b0001);
        check("respawn_wrap_x0", 32'(xof(0)), 224);
        check("respawn_y0", 32'(yof(0)), 0);
        check("retired_y1", 32'(yof(1)), 0);
        check("respawn_pulse", 32'(ifc.spawn_pulse), 1);

        ifc.player_speed = 4'd2;
        ifc.frame_tick = 1'b1;
        step(3);
        ifc.frame_tick = 1'b0;
        step(3);
        check("busy_tick_once", 32'(yof(0)), 2);
        step(N + 2);
        check("busy_tick_still", 32'(yof(0)), 2);

        ifc.run = 1'b0;
        ifc.frame_tick = 1'b1;
        step(3);
        ifc.frame_tick = 1'b0;
        step(5);
        check("pause_y0", 32'(yof(0)), 2);
        check("pause_busy", 32'(ifc.busy), 0);
        check("pause_active", 32'(ifc.car_active), 4'b0001);
        ifc.run = 1'b1;

        ifc.frame_tick = 1'b1;
        step();
        ifc.frame_tick = 1'b0;
        step(2);
        check("pre_abort_y0", 32'(yof(0)), 4);
        reset = 1'b0;
        step();
        check("abort_active", 32'(ifc.car_active), 0);
        check("abort_x", 32'(ifc.car_x), 0);
        check("abort_y", 32'(ifc.car_y), 0);
        check("abort_busy", 32'(ifc.busy), 0);
        check("abort_pulse", 32'(ifc.spawn_pulse), 0);
        reset = 1'b1;
        step();
        ifc.frame_tick = 1'b1;
        step();
        ifc.frame_tick = 1'b0;
        check("abort_to_wait", 32'(ifc.busy), 1);
        step(N + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
